// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one 5-bit combinational ALU among NREQ requesters
//
// Ports:
//    clk, reset           clock; asynchronous active-high reset
//    req                  per-requester request level
//    req_a, req_b         packed 5-bit operands, requester i at [5i+4:5i]
//    req_op               packed 2-bit ALU control, requester i at [2i+1:2i]
//    gnt                  one-hot grant pulse, high only during the ISSUE cycle
//    alu_a/alu_b/alu_ctrl registered drive to the shared ALU
//    alu_result/flags     ALU outputs, captured at the end of ISSUE
//    rsp_valid/id/result/flags, rsp_ack  response handshake
//    busy                 high whenever an operation is in flight
module alu_share_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*5-1:0] req_a,
   input  logic [NREQ*5-1:0] req_b,
   input  logic [NREQ*2-1:0] req_op,
   output logic [NREQ-1:0]   gnt,
   output logic [4:0]        alu_a,
   output logic [4:0]        alu_b,
   output logic [1:0]        alu_ctrl,
   input  logic [8:0]        alu_result,
   input  logic [3:0]        alu_flags,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [8:0]        rsp_result,
   output logic [3:0]        rsp_flags,
   input  logic              rsp_ack,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t                 state_q, state_d;
   logic [IDW-1:0]         ptr_q, ptr_d, win, cand;
   logic [NREQ-1:0]        gnt_q, gnt_d;
   logic [4:0]             alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [1:0]             alu_ctrl_q, alu_ctrl_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]         rsp_id_q, rsp_id_d;
   logic [8:0]             rsp_result_q, rsp_result_d;
   logic [3:0]             rsp_flags_q, rsp_flags_d;
   logic [NREQ-1:0][4:0]   a_v, b_v;
   logic [NREQ-1:0][1:0]   op_v;
   assign a_v  = req_a;
   assign b_v  = req_b;
   assign op_v = req_op;
   // Scan from the farthest candidate back to ptr+1 so the nearest asserted
   // requester after the last winner is the one left in win.
   always_comb begin
      win  = '0;
      cand = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IDW'((int'(ptr_q) + k) % NREQ);
         if (req[cand]) win = cand;
      end
   end
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      gnt_d        = gnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_ctrl_d   = alu_ctrl_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      case (state_q)
         IDLE: if (|req) begin
            alu_a_d    = a_v[win];
            alu_b_d    = b_v[win];
            alu_ctrl_d = op_v[win];
            gnt_d      = NREQ'(1) << win;
            rsp_id_d   = win;
            ptr_d      = win;
            state_d    = ISSUE;
         end
         ISSUE: begin
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags;
            gnt_d        = '0;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
         end
         RESP: if (rsp_ack) begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= IDW'(NREQ - 1);
         gnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         gnt_q        <= gnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
      end
   end
   assign gnt        = gnt_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_ctrl   = alu_ctrl_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;
   assign busy       = state_q != IDLE;
   // The grant pulse exists only while the ALU is being driven for that requester.
   assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
   assert property (@(posedge clk) disable iff (reset) (gnt_q != '0) |-> (state_q == ISSUE));
   assert property (@(posedge clk) disable iff (reset)
      (state_q == RESP && !rsp_ack) |=> (rsp_valid_q && $stable(rsp_result_q) && $stable(rsp_id_q)));
endmodule
